// File: rtl/ir_encoder.sv
// MIPS instruction word encoder: mnemonic ID + operand fields -> 32-bit IR words, queued in a FIFO
// and streamed with byte addresses. Define DELAY_SLOT_NOP_EN to follow every branch/jump with a NOP.
module ir_encoder #(
   parameter int unsigned DEPTH     = 4,
   parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [5:0]  mnem,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [4:0]  shamt,
   input  logic [15:0] imm,
   input  logic [25:0] target,
   output logic        ir_valid,
   input  logic        ir_ready,
   output logic [31:0] ir_data,
   output logic [31:0] ir_addr,
   output logic        err
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [PW-1:0] PTR_ONE = PW'(1);

   logic [31:0] word;
   logic        legal;
   logic        is_branch;

   always_comb begin
      word      = '0;
      legal     = 1'b1;
      is_branch = 1'b0;
      case (mnem)
         6'd0:  word = {6'd0, rs, rt, rd, 5'd0, 6'h21};
         6'd1:  word = {6'd0, rs, rt, rd, 5'd0, 6'h23};
         6'd2:  word = {6'd0, rs, rt, rd, 5'd0, 6'h2a};
         6'd3:  word = {6'd0, rs, rt, rd, 5'd0, 6'h2b};
         6'd4:  word = {6'd0, 5'd0, rt, rd, shamt, 6'h00};
         6'd5:  word = {6'd0, 5'd0, rt, rd, shamt, 6'h03};
         6'd6:  word = {6'd0, 5'd0, rt, rd, shamt, 6'h02};
         6'd7:  word = {6'd0, rs, rt, rd, 5'd0, 6'h24};
         6'd8:  word = {6'd0, rs, rt, rd, 5'd0, 6'h27};
         6'd9:  word = {6'd0, rs, rt, rd, 5'd0, 6'h25};
         6'd10: word = {6'd0, rs, rt, rd, 5'd0, 6'h26};
         6'd11: word = {6'd0, rs, rt, rd, 5'd0, 6'h04};
         6'd12: word = {6'd0, rs, rt, rd, 5'd0, 6'h07};
         6'd13: word = {6'd0, rs, rt, rd, 5'd0, 6'h06};
         6'd14: begin word = {6'd0, rs, 5'd0, rd, 5'd0, 6'h09};  is_branch = 1'b1; end
         6'd15: begin word = {6'd0, rs, 15'd0, 6'h08};           is_branch = 1'b1; end
         6'd16: begin word = {6'h01, rs, 5'd1, imm};             is_branch = 1'b1; end
         6'd17: begin word = {6'h01, rs, 5'd0, imm};             is_branch = 1'b1; end
         6'd18: word = {6'h2b, rs, rt, imm};
         6'd19: word = {6'h28, rs, rt, imm};
         6'd20: word = {6'h23, rs, rt, imm};
         6'd21: word = {6'h20, rs, rt, imm};
         6'd22: word = {6'h24, rs, rt, imm};
         6'd23: word = {6'h0a, rs, rt, imm};
         6'd24: word = {6'h0b, rs, rt, imm};
         6'd25: word = {6'h0c, rs, rt, imm};
         6'd26: word = {6'h0d, rs, rt, imm};
         6'd27: word = {6'h0e, rs, rt, imm};
         6'd28: word = {6'h0f, 5'd0, rt, imm};
         6'd29: word = {6'h09, rs, rt, imm};
         6'd30: begin word = {6'h04, rs, rt, imm};               is_branch = 1'b1; end
         6'd31: begin word = {6'h07, rs, 5'd0, imm};             is_branch = 1'b1; end
         6'd32: begin word = {6'h06, rs, 5'd0, imm};             is_branch = 1'b1; end
         6'd33: begin word = {6'h05, rs, rt, imm};               is_branch = 1'b1; end
         6'd34: begin word = {6'h02, target};                    is_branch = 1'b1; end
         6'd35: begin word = {6'h03, target};                    is_branch = 1'b1; end
         default: legal = 1'b0;
      endcase
   end

   logic [31:0]   mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic [31:0]   addr_q;
   logic          err_q;
   logic          accept, push, pop, push_nop;
   logic [CW-1:0] push_n;

   assign accept = req_valid && req_ready;
   assign push   = accept && legal;
   assign pop    = ir_valid && ir_ready;

`ifdef DELAY_SLOT_NOP_EN
   // A branch needs room for itself plus its delay-slot NOP.
   assign push_nop  = push && is_branch;
   assign req_ready = (count_q <= CW'(DEPTH - 2));
`else
   assign push_nop  = 1'b0;
   assign req_ready = (count_q != CW'(DEPTH));
`endif

   assign push_n = push ? (push_nop ? CW'(2) : CW'(1)) : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         addr_q   <= BASE_ADDR;
         err_q    <= 1'b0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= word;
            if (push_nop) mem_q[wr_ptr_q + PTR_ONE] <= '0;
            wr_ptr_q <= wr_ptr_q + PW'(push_n);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
            addr_q   <= addr_q + 32'd4;
         end
         count_q <= count_q + push_n - CW'(pop);
         if (accept && !legal) err_q <= 1'b1;
      end
   end

   assign ir_valid = (count_q != '0);
   assign ir_data  = mem_q[rd_ptr_q];
   assign ir_addr  = addr_q;
   assign err      = err_q;

endmodule

// File: tb/tb_ir_encoder.sv
// Self-checking bench for ir_encoder: directed vector table, hand sequences and random traffic
// against a queue-based reference model.
module tb_ir_encoder;

   localparam int unsigned DEPTH = 4;
   localparam logic [31:0] BASE  = 32'h0000_3000;
`ifdef DELAY_SLOT_NOP_EN
   localparam int NEED = 2;
`else
   localparam int NEED = 1;
`endif
   localparam int FILL = int'(DEPTH) - NEED + 1;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        req_valid = 1'b0, req_ready;
   logic [5:0]  mnem = '0;
   logic [4:0]  rs = '0, rt = '0, rd = '0, shamt = '0;
   logic [15:0] imm = '0;
   logic [25:0] target = '0;
   logic        ir_valid, ir_ready = 1'b0;
   logic [31:0] ir_data, ir_addr;
   logic        err;

   ir_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
      .mnem(mnem), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm(imm), .target(target),
      .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_data(ir_data), .ir_addr(ir_addr), .err(err)
   );

   always #5 clk = ~clk;

   int          n_tests = 0, n_fail = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_addr_q[$];
   logic [31:0] m_addr = BASE;
   bit          m_err = 1'b0;
   bit          mon_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", name, act, req);
      end
   endtask

   // Reference encoder built from field-placement rules and opcode/funct lookup tables.
   function automatic logic [31:0] ref_enc(input int m, input int f_rs, input int f_rt,
                                           input int f_rd, input int f_sh, input int f_imm,
                                           input int f_tgt, output bit legal, output bit br);
      int r_funct[16] = '{33, 35, 42, 43, 0, 3, 2, 36, 39, 37, 38, 4, 7, 6, 9, 8};
      int i_op[16]    = '{43, 40, 35, 32, 36, 10, 11, 12, 13, 14, 15, 9, 4, 7, 6, 5};
      int s, t, d, h;
      logic [31:0] w;
      legal = (m <= 35);
      br    = (m >= 14 && m <= 17) || (m >= 30 && m <= 35);
      s = f_rs; t = f_rt; d = f_rd; h = f_sh;
      w = '0;
      if (m <= 15) begin
         if (m >= 4 && m <= 6) s = 0; else h = 0;
         if (m == 14 || m == 15) t = 0;
         if (m == 15) d = 0;
         w = 32'(s * (1 << 21) + t * (1 << 16) + d * (1 << 11) + h * 64 + r_funct[m]);
      end else if (m <= 17) begin
         w = {6'd1, 26'(s * (1 << 21) + ((m == 16) ? 1 : 0) * (1 << 16) + f_imm)};
      end else if (m <= 33) begin
         if (m == 28) s = 0;
         if (m == 31 || m == 32) t = 0;
         w = {6'(i_op[m - 18]), 26'(s * (1 << 21) + t * (1 << 16) + f_imm)};
      end else if (legal) begin
         w = {6'(m - 32), 26'(f_tgt)};
      end
      return w;
   endfunction

   function automatic bit ready_ref();
      return (int'(DEPTH) - exp_q.size()) >= NEED;
   endfunction

   // Cycle monitor: compares DUT against the model, then advances the model across the next edge.
   always @(negedge clk) begin
      if (mon_en && reset_n) begin
         bit rdy, lg, br;
         logic [31:0] w;
         rdy = ready_ref();
         check("req_ready", 32'(req_ready), 32'(rdy));
         check("ir_valid", 32'(ir_valid), 32'(exp_q.size() != 0));
         if (exp_q.size() != 0) begin
            check("ir_data", ir_data, exp_q[0]);
            check("ir_addr", ir_addr, exp_addr_q[0]);
         end
         check("err", 32'(err), 32'(m_err));
         if (exp_q.size() != 0 && ir_ready) begin
            void'(exp_q.pop_front());
            void'(exp_addr_q.pop_front());
         end
         if (req_valid && rdy) begin
            w = ref_enc(int'(mnem), int'(rs), int'(rt), int'(rd), int'(shamt), int'(imm),
                        int'(target), lg, br);
            if (lg) begin
               exp_q.push_back(w);
               exp_addr_q.push_back(m_addr);
               m_addr += 32'd4;
`ifdef DELAY_SLOT_NOP_EN
               if (br) begin
                  exp_q.push_back(32'h0);
                  exp_addr_q.push_back(m_addr);
                  m_addr += 32'd4;
               end
`endif
            end else begin
               m_err = 1'b1;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int m, input int a, input int b, input int c, input int sh,
                          input int im, input int tg);
      mnem = 6'(m); rs = 5'(a); rt = 5'(b); rd = 5'(c); shamt = 5'(sh);
      imm = 16'(im); target = 26'(tg); req_valid = 1'b1;
   endtask

   task automatic do_reset();
      req_valid = 1'b0;
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("rst_ir_valid", 32'(ir_valid), 32'h0);
      check("rst_err", 32'(err), 32'h0);
      check("rst_ir_addr", ir_addr, BASE);
      check("rst_ir_data", ir_data, 32'h0);
      exp_q.delete();
      exp_addr_q.delete();
      m_addr = BASE;
      m_err  = 1'b0;
      @(posedge clk);
      #1 reset_n = 1'b1;
      check("rst_req_ready", 32'(req_ready), 32'h1);
      mon_en = 1'b1;
   endtask

   task automatic drain();
      for (int k = 0; k < 20 && ir_valid; k++) tick();
      check("drain", 32'(ir_valid), 32'h0);
   endtask

   typedef struct {
      int m, a, b, c, sh, im, tg;
      bit br;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[$];
   logic [31:0] ea;

   initial begin
      vecs.push_back('{0,  1,  2,  3,  7, 0,      0,        0, 32'h00221821}); // addu
      vecs.push_back('{26, 0,  1,  0,  0, 'h1234, 0,        0, 32'h34011234}); // ori
      vecs.push_back('{28, 5,  2,  0,  0, 'hABCD, 0,        0, 32'h3C02ABCD}); // lui
      vecs.push_back('{30, 1,  2,  0,  0, 'hFFFF, 0,        1, 32'h1022FFFF}); // beq
      vecs.push_back('{34, 0,  0,  0,  0, 0,      'h100000, 1, 32'h08100000}); // j
      vecs.push_back('{4,  7,  5,  4,  3, 0,      0,        0, 32'h000520C0}); // sll
      vecs.push_back('{15, 31, 1,  2,  3, 0,      0,        1, 32'h03E00008}); // jr
      vecs.push_back('{14, 2,  5,  31, 1, 0,      0,        1, 32'h0040F809}); // jalr
      vecs.push_back('{16, 3,  7,  0,  0, 'h10,   0,        1, 32'h04610010}); // bgez
      vecs.push_back('{17, 3,  7,  0,  0, 'h10,   0,        1, 32'h04600010}); // bltz
      vecs.push_back('{20, 29, 8,  0,  0, 4,      0,        0, 32'h8FA80004}); // lw
      vecs.push_back('{35, 0,  0,  0,  0, 0,      'h3FFFFFF,1, 32'h0FFFFFFF}); // jal
      vecs.push_back('{32, 4,  9,  0,  0, 'h8000, 0,        1, 32'h18808000}); // blez
      vecs.push_back('{11, 2,  3,  1,  9, 0,      0,        0, 32'h00430804}); // sllv
      vecs.push_back('{27, 1,  2,  0,  0, 'hFFFF, 0,        0, 32'h3822FFFF}); // xori
      vecs.push_back('{18, 29, 31, 0,  0, 'hFFFC, 0,        0, 32'hAFBFFFFC}); // sw

      do_reset();

      // Directed encodings, one at a time through an empty FIFO.
      ir_ready = 1'b1;
      ea = BASE;
      foreach (vecs[i]) begin
         drain();
         set_req(vecs[i].m, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].sh, vecs[i].im, vecs[i].tg);
         tick();
         req_valid = 1'b0;
         check("vec_valid", 32'(ir_valid), 32'h1);
         check("vec_data", ir_data, vecs[i].exp);
         check("vec_addr", ir_addr, ea);
         ea += 32'd4;
         tick();
`ifdef DELAY_SLOT_NOP_EN
         if (vecs[i].br) begin
            check("vec_nop", ir_data, 32'h0);
            check("vec_nop_addr", ir_addr, ea);
            ea += 32'd4;
            tick();
         end
`endif
         check("vec_valid_after", 32'(ir_valid), 32'h0);
      end

      // Random traffic with backpressure; the monitor checks every cycle.
      for (int c = 0; c < 800; c++) begin
         set_req(($urandom_range(0, 19) == 0) ? 36 + int'($urandom_range(0, 27))
                                              : int'($urandom_range(0, 35)),
                 int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                 int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                 int'($urandom_range(0, 65535)), int'($urandom & 32'h03FF_FFFF));
         req_valid = ($urandom_range(0, 3) != 0);
         ir_ready  = ($urandom_range(0, 2) != 0);
         tick();
      end
      req_valid = 1'b0;
      ir_ready  = 1'b1;
      drain();

      // Fill until backpressure, hold output, then release.
      do_reset();
      ir_ready = 1'b0;
      for (int i = 0; i < FILL; i++) begin
         set_req(0, 1, 2, i + 1, 0, 0, 0);
         tick();
      end
      req_valid = 1'b0;
      check("full_ready", 32'(req_ready), 32'h0);
      check("full_valid", 32'(ir_valid), 32'h1);
      tick();
      tick();
      check("hold_data", ir_data, 32'h00220821);
      check("hold_addr", ir_addr, BASE);
      ir_ready = 1'b1;
      tick();
      check("ready_after_pop", 32'(req_ready), 32'h1);
      check("second_word", ir_data, 32'h00221021);
      check("second_addr", ir_addr, BASE + 32'd4);
      drain();

      // Illegal mnemonic: handshake completes, nothing queued, err sticks.
      check("ill_ready", 32'(req_ready), 32'h1);
      set_req(40, 1, 2, 3, 0, 0, 0);
      tick();
      req_valid = 1'b0;
      check("ill_err", 32'(err), 32'h1);
      check("ill_valid", 32'(ir_valid), 32'h0);
      tick();
      check("ill_err_sticky", 32'(err), 32'h1);
      set_req(0, 1, 2, 3, 0, 0, 0);
      tick();
      req_valid = 1'b0;
      check("post_ill_valid", 32'(ir_valid), 32'h1);
      check("post_ill_data", ir_data, 32'h00221821);
      drain();

      // Reset with words queued.
      ir_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_req(0, 1, 2, 3, 0, 0, 0);
         tick();
      end
      req_valid = 1'b0;
      check("queued_valid", 32'(ir_valid), 32'h1);
      do_reset();
      ir_ready = 1'b1;
      set_req(26, 0, 1, 0, 0, 'h1234, 0);
      tick();
      req_valid = 1'b0;
      check("post_rst_data", ir_data, 32'h34011234);
      check("post_rst_addr", ir_addr, BASE);
      drain();

      mon_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
